// File: rtl/uart_pkg.sv
// Shared UART constants: receiver state encoding, default frame geometry and baud divider.
package uart_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t IDLE  = 3'd0;
    localparam rx_state_t START = 3'd1;
    localparam rx_state_t DATA  = 3'd2;
    localparam rx_state_t STOP  = 3'd3;
    localparam rx_state_t BREAK = 3'd4;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;
    // 100 MHz system clock, 9600 baud, 16x oversampling
    localparam int unsigned BAUD_DIV = 100_000_000 / 9600 / 16;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to RESET_VAL.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver (8N1 default) with start glitch rejection and break handling.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote over the last three ticks.
module uart_receiver import uart_pkg::*; #(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 sample;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Holds rx_s from the two previous br_ticks; the third vote is the live rx_s at tick T.
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else if (br_tick) begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample = majority3({hist_q, rx_s});
`else
    assign sample = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (br_tick) begin
                    if (tick_q == TICK_MID) begin
                        state_d = sample ? IDLE : DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (br_tick) begin
                    if (tick_q == TICK_LAST) begin
                        shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            STOP: begin
                if (br_tick) begin
                    if (tick_q == TICK_LAST) begin
                        data_d  = shreg_q;
                        done_d  = 1'b1;
                        ferr_d  = ~sample;
                        tick_d  = '0;
                        // A low stop bit parks in BREAK so a held-low line is not read as 0x00s
                        state_d = sample ? IDLE : BREAK;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames queue expected bytes, a monitor checks rx_done.
module tb_uart_receiver;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       br_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;

    int   checks   = 0;
    int   errors   = 0;
    int   tick_no  = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];
    int   done_ticks[$];

    always #5 clk = ~clk;

    uart_receiver #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .br_tick   (br_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One oversample period: drive rx, let the synchronizer settle, then a single br_tick.
    task automatic tick(input logic v);
        @(negedge clk) rx = v;
        repeat (3) @(negedge clk);
        br_tick = 1'b1;
        tick_no++;
        @(negedge clk) br_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    // 160-tick frame; glitch forces one tick high, abort_at pulses reset at that tick.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch,
                              input int abort_at);
        for (int s = 0; s < 160; s++) begin
            logic v;
            if (s == abort_at) begin
                @(negedge clk) reset = 1'b1;
                rx = 1'b1;
                @(negedge clk);
                check("reset_rx_data", 32'(rx_data), 32'h0);
                check("reset_frame_err", 32'(frame_err), 32'h0);
                check("reset_rx_done", 32'(rx_done), 32'h0);
                reset = 1'b0;
                return;
            end
            if (s < 16) v = 1'b0;
            else if (s < 144) v = d[s/16-1];
            else v = stop;
            if (s == glitch) v = 1'b1;
            tick(v);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rx_done) begin
            done_cnt++;
            done_ticks.push_back(tick_no);
            check("rx_done_width", 32'(prev_done), 32'h0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rx_done: got rx_data %0h expected no frame", rx_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("frame_err", 32'(frame_err), 32'(e.ferr));
            end
        end
        prev_done = rx_done;
    end

    initial begin
        exp_t e;
        rx      = 1'b1;
        br_tick = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        check("init_rx_data", 32'(rx_data), 32'h0);
        check("init_rx_done", 32'(rx_done), 32'h0);
        check("init_frame_err", 32'(frame_err), 32'h0);
        check("init_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;
        idle(4);

        // Basic frame
        e = '{data: 8'h55, ferr: 1'b0}; sb.push_back(e);
        send_frame(8'h55, 1'b1, -1, -1);
        idle(4);
        check("state_after_55", 32'(dut.state_q), 32'(IDLE));
        check("done_cnt_55", 32'(done_cnt), 32'd1);

        // Back-to-back, no idle gap
        e = '{data: 8'hA3, ferr: 1'b0}; sb.push_back(e);
        e = '{data: 8'h0F, ferr: 1'b0}; sb.push_back(e);
        send_frame(8'hA3, 1'b1, -1, -1);
        send_frame(8'h0F, 1'b1, -1, -1);
        check("done_cnt_b2b", 32'(done_cnt), 32'd3);
        if (done_ticks.size() >= 3)
            check("b2b_spacing", 32'(done_ticks[2] - done_ticks[1]), 32'd160);

        // Short start glitch is rejected
        for (int i = 0; i < 4; i++) tick(1'b0);
        idle(12);
        check("glitch_rx_data", 32'(rx_data), 32'h0F);
        check("glitch_state", 32'(dut.state_q), 32'(IDLE));
        check("glitch_done_cnt", 32'(done_cnt), 32'd3);

        // Low stop bit, held-low line, then recovery
        e = '{data: 8'h81, ferr: 1'b1}; sb.push_back(e);
        send_frame(8'h81, 1'b0, -1, -1);
        for (int i = 0; i < 40; i++) tick(1'b0);
        check("break_state", 32'(dut.state_q), 32'(BREAK));
        check("break_done_cnt", 32'(done_cnt), 32'd4);
        check("break_frame_err_held", 32'(frame_err), 32'h1);
        idle(4);
        check("break_exit_state", 32'(dut.state_q), 32'(IDLE));
        e = '{data: 8'h3C, ferr: 1'b0}; sb.push_back(e);
        send_frame(8'h3C, 1'b1, -1, -1);

        // Reset during data bit 4, then a clean retry
        send_frame(8'hC6, 1'b1, -1, 16 * 5 + 5);
        idle(4);
        check("abort_done_cnt", 32'(done_cnt), 32'd5);
        e = '{data: 8'hC6, ferr: 1'b0}; sb.push_back(e);
        send_frame(8'hC6, 1'b1, -1, -1);

        // One-tick high pulse on bit 2 of 0x00 (tick 14, then tick 15 = sampling tick)
        e = '{data: 8'h00, ferr: 1'b0}; sb.push_back(e);
        send_frame(8'h00, 1'b1, 54, -1);
`ifdef UART_RX_MAJORITY_EN
        e = '{data: 8'h00, ferr: 1'b0}; sb.push_back(e);
`else
        e = '{data: 8'h04, ferr: 1'b0}; sb.push_back(e);
`endif
        send_frame(8'h00, 1'b1, 55, -1);

        e = '{data: 8'h7E, ferr: 1'b0}; sb.push_back(e);
        send_frame(8'h7E, 1'b1, -1, -1);
        idle(4);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("total_done_cnt", 32'(done_cnt), 32'd9);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
